// File: rtl/store_trace_fifo_if.sv
// ---------------------------------------------------------------------------
// store_trace_fifo_if
//   Read-side handshake of the store trace FIFO. The FIFO drives the head
//   entry and rd_valid. The debug host drives rd_ready.
//   master : FIFO side  (drives rd_valid/rd_pc/rd_addr/rd_wdata, samples rd_ready)
//   slave  : host side  (samples the entry, drives rd_ready)
// ---------------------------------------------------------------------------
interface store_trace_fifo_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_addr;
  logic [31:0] rd_wdata;

  modport master (
    output rd_valid, rd_pc, rd_addr, rd_wdata,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_addr, rd_wdata,
    output rd_ready
  );
endinterface

// File: rtl/store_trace_fifo.sv
// ---------------------------------------------------------------------------
// store_trace_fifo
//   Passive trace buffer on the CPU data-memory write bus. Every store
//   (DM_CS & DM_W) seen while capture is active is pushed as {pc, addr, wdata}
//   into a DEPTH-entry FIFO. The FIFO is read through a first-word-fall-through
//   valid/ready port. The block never stalls the CPU. When the FIFO is full,
//   stores are dropped and counted.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   pc, addr, wdata       observed memory bus
//   DM_CS, DM_W           chip select / write strobe; both high = store event
//   clear                 synchronous flush; has priority over arm, push and pop
//   arm                   start/restart capture (does not flush)
//   trig_en, trig_pc      trigger on pc == trig_pc before capturing
//   stop_on_full          freeze capture (DONE) once the FIFO fills
//   rd                    read handshake interface (master side)
//   count                 occupancy 0..DEPTH
//   overflow, drop_cnt    sticky drop flag and saturating drop counter
//   state                 IDLE=0, ARMED=1, CAPTURE=2, DONE=3
// ---------------------------------------------------------------------------
module store_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic                       DM_CS,
  input  logic                       DM_W,
  input  logic                       clear,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [31:0]                trig_pc,
  input  logic                       stop_on_full,
  store_trace_fifo_if.master         rd,
  output logic [AW:0]                count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q;
  logic [15:0]     drop_cnt_q;
  entry_t          mem [DEPTH];

  logic store_ev, trig_hit, eligible, full, pop, push, drop;

  // Capture eligibility uses the current state. An arm in this cycle only
  // affects stores from the next cycle on. ARMED captures the triggering store.
  assign store_ev = DM_CS & DM_W;
  assign trig_hit = (state_q == ARMED) && (pc == trig_pc);
  assign eligible = store_ev && ((state_q == CAPTURE) || trig_hit);
  assign full     = (count_q == FULL_CNT);
  assign pop      = rd.rd_valid && rd.rd_ready;
  // When full, a push is accepted only if a pop frees the head slot this cycle.
  assign push     = eligible && (!full || pop);
  assign drop     = eligible && full && !pop;

  // NOTE: every signal assigned in always_comb gets a default first, so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    state_d = state_q;
    unique case (state_q)
      IDLE:    ;
      ARMED:   if (trig_hit) state_d = (stop_on_full && count_d == FULL_CNT) ? DONE : CAPTURE;
      CAPTURE: if (stop_on_full && count_d == FULL_CNT) state_d = DONE;
      DONE:    ;
      default: state_d = IDLE;
    endcase
    // arm restarts from any state without flushing the FIFO.
    if (arm) state_d = trig_en ? ARMED : CAPTURE;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and simulation ordering cannot leak into results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH (power of two)
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset. Validity is tracked by the pointers
  // and count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= '{pc: pc, addr: addr, wdata: wdata};
  end

  // First-word-fall-through: the head entry is visible whenever non-empty.
  entry_t head;
  assign head        = mem[rd_ptr];
  assign rd.rd_valid = (count_q != '0);
  assign rd.rd_pc    = head.pc;
  assign rd.rd_addr  = head.addr;
  assign rd.rd_wdata = head.wdata;

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_store_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_store_trace_fifo
//   Directed bench for store_trace_fifo (DEPTH=16). Inputs change 1 ns after
//   the rising edge, and outputs are checked there as well.
// ---------------------------------------------------------------------------
module tb_store_trace_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0, addr = '0, wdata = '0, trig_pc = '0;
  logic        DM_CS = 1'b0, DM_W = 1'b0;
  logic        clear = 1'b0, arm = 1'b0, trig_en = 1'b0, stop_on_full = 1'b0;
  logic [AW:0] count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  store_trace_fifo_if rd_if ();

  store_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .addr         (addr),
    .wdata        (wdata),
    .DM_CS        (DM_CS),
    .DM_W         (DM_W),
    .clear        (clear),
    .arm          (arm),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .stop_on_full (stop_on_full),
    .rd           (rd_if.master),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    pc = p; addr = a; wdata = d; DM_CS = 1'b1; DM_W = 1'b1;
    tick();
    DM_CS = 1'b0; DM_W = 1'b0; pc = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_if.rd_ready = 1'b1;
    repeat (n) tick();
    rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    #12 reset = 1'b1;
    tick();

    // Reset state
    check("rst_valid", 32'(rd_if.rd_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_drop",  32'(drop_cnt), 0);
    check("rst_state", 32'(state), 0);

    // Basic capture, immediate start
    trig_en = 1'b0;
    pulse_arm();
    check("arm_capture", 32'(state), 2);
    store(32'h0040_0000, 32'h10, 32'h11);
    check("basic_push_lat", 32'(count), 1);
    store(32'h0040_0004, 32'h14, 32'h22);
    store(32'h0040_0008, 32'h18, 32'h33);
    check("basic_count", 32'(count), 3);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("basic_valid", 32'(rd_if.rd_valid), 1);
      check("basic_pc",    rd_if.rd_pc,    32'h0040_0000 + 32'(4 * i));
      check("basic_addr",  rd_if.rd_addr,  32'h10 + 32'(4 * i));
      check("basic_wdata", rd_if.rd_wdata, 32'h11 * 32'(i + 1));
      tick();
    end
    rd_if.rd_ready = 1'b0;
    check("basic_empty", 32'(rd_if.rd_valid), 0);
    check("basic_count0", 32'(count), 0);

    // Trigger on PC
    pulse_clear();
    trig_en = 1'b1; trig_pc = 32'h0040_001C;
    pulse_arm();
    check("trig_armed", 32'(state), 1);
    store(32'h0040_0010, 32'h1, 32'h1);
    store(32'h0040_0014, 32'h2, 32'h2);
    check("trig_ignored", 32'(count), 0);
    check("trig_still_armed", 32'(state), 1);
    store(32'h0040_001C, 32'h20, 32'hAB);
    check("trig_capture", 32'(state), 2);
    check("trig_count", 32'(count), 1);
    check("trig_pc",    rd_if.rd_pc,    32'h0040_001C);
    check("trig_addr",  rd_if.rd_addr,  32'h20);
    check("trig_wdata", rd_if.rd_wdata, 32'hAB);
    trig_en = 1'b0;

    // Overflow, stop_on_full=0
    pulse_clear();
    check("clr_state", 32'(state), 0);
    stop_on_full = 1'b0;
    pulse_arm();
    for (int i = 0; i < 20; i++) store(32'h1000 + 32'(4 * i), 32'(i), 32'h100 + 32'(i));
    check("ovf_count", 32'(count), 16);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_drop",  32'(drop_cnt), 4);
    check("ovf_state", 32'(state), 2);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_rd_pc",    rd_if.rd_pc,    32'h1000 + 32'(4 * i));
      check("ovf_rd_wdata", rd_if.rd_wdata, 32'h100 + 32'(i));
      tick();
    end
    rd_if.rd_ready = 1'b0;
    check("ovf_drained", 32'(rd_if.rd_valid), 0);

    // Stop on full
    pulse_clear();
    stop_on_full = 1'b1;
    pulse_arm();
    for (int i = 0; i < 16; i++) store(32'h2000 + 32'(4 * i), 32'(i), 32'h200 + 32'(i));
    check("sof_state", 32'(state), 3);
    check("sof_count", 32'(count), 16);
    pop_n(2);
    check("sof_pop_count", 32'(count), 14);
    for (int i = 0; i < 3; i++) store(32'h3000, 32'h0, 32'hDEAD);
    check("sof_count_after", 32'(count), 14);
    check("sof_drop", 32'(drop_cnt), 0);
    check("sof_ovf",  32'(overflow), 0);
    check("sof_state_after", 32'(state), 3);
    check("sof_head", rd_if.rd_wdata, 32'h202);

    // Full with simultaneous push and pop
    pulse_clear();
    stop_on_full = 1'b0;
    pulse_arm();
    for (int i = 0; i < 16; i++) store(32'h4000, 32'(i), 32'(i));
    check("fpp_full", 32'(count), 16);
    rd_if.rd_ready = 1'b1;
    store(32'h4100, 32'hE0, 32'hEE);
    rd_if.rd_ready = 1'b0;
    check("fpp_count", 32'(count), 16);
    check("fpp_drop",  32'(drop_cnt), 0);
    check("fpp_ovf",   32'(overflow), 0);
    check("fpp_head",  rd_if.rd_wdata, 32'd1);
    pop_n(15);
    check("fpp_tail_count", 32'(count), 1);
    check("fpp_tail", rd_if.rd_wdata, 32'hEE);
    check("fpp_tail_pc", rd_if.rd_pc, 32'h4100);

    // Empty with simultaneous push and pop
    pulse_clear();
    pulse_arm();
    rd_if.rd_ready = 1'b1;
    store(32'h5000, 32'h50, 32'h55);
    rd_if.rd_ready = 1'b0;
    check("epp_count", 32'(count), 1);
    check("epp_data",  rd_if.rd_wdata, 32'h55);

    // clear together with arm, count=5, drop_cnt=2
    pulse_clear();
    pulse_arm();
    for (int i = 0; i < 18; i++) store(32'h6000, 32'(i), 32'(i));
    pop_n(11);
    check("ca_pre_count", 32'(count), 5);
    check("ca_pre_drop",  32'(drop_cnt), 2);
    clear = 1'b1; arm = 1'b1;
    tick();
    clear = 1'b0; arm = 1'b0;
    check("ca_count", 32'(count), 0);
    check("ca_drop",  32'(drop_cnt), 0);
    check("ca_ovf",   32'(overflow), 0);
    check("ca_state", 32'(state), 0);
    check("ca_valid", 32'(rd_if.rd_valid), 0);

    // Asynchronous reset mid-capture
    pulse_arm();
    for (int i = 0; i < 3; i++) store(32'h7000, 32'(i), 32'(i));
    check("ar_pre_count", 32'(count), 3);
    #2 reset = 1'b0;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_valid", 32'(rd_if.rd_valid), 0);
    check("ar_state", 32'(state), 0);
    check("ar_ovf",   32'(overflow), 0);
    check("ar_drop",  32'(drop_cnt), 0);
    #2 reset = 1'b1;
    tick();
    check("ar_after", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_trace_fifo.md
# store_trace_fifo

Debug trace buffer that sits directly downstream of the CPU top level. It watches the data-memory write bus (pc, addr, wdata, DM_CS, DM_W) and captures each store into a FIFO, starting either immediately or on a PC trigger. Entries are read out through a valid/ready handshake by a debug host, such as a UART dumper or the board display driver. It is purely an observer: it never back-pressures or alters the CPU.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2
- AW, 4, log2(DEPTH); pointer width
- clk  in  1  CPU clock; the same net as the top level's clk output
- reset  in  1  asynchronous, active-low; 0 clears all state
- pc  in  32  PC of the instruction driving the memory bus this cycle
- addr  in  32  data-memory address
- wdata  in  32  data-memory write data
- DM_CS  in  1  data-memory chip select
- DM_W  in  1  data-memory write strobe
- clear  in  1  synchronous flush, one-cycle pulse
- arm  in  1  start request, one-cycle pulse
- trig_en  in  1  1: wait for trig_pc before capturing; 0: capture on arm
- trig_pc  in  32  trigger PC
- stop_on_full  in  1  1: stop capturing permanently once full; 0: keep running and drop new events
- rd_ready  in  1  host accepts the head entry
- rd_valid  out  1  FIFO non-empty
- rd_pc  out  32  head entry PC
- rd_addr  out  32  head entry address
- rd_wdata  out  32  head entry data
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set when a store event is dropped
- drop_cnt  out  16  dropped events; saturates at 16'hFFFF
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- Store event: DM_CS & DM_W, sampled at a rising edge of clk.
- The event is eligible for capture only when the capture condition holds in that cycle.
- State machine:
  - IDLE: on arm, go to ARMED if trig_en=1, otherwise go to CAPTURE.
  - ARMED: when pc==trig_pc, go to CAPTURE. A store in that same cycle is captured.
  - CAPTURE: eligible events are pushed. If stop_on_full=1 and count reaches DEPTH, go to DONE.
  - DONE: no capture. Pops remain allowed. Only arm or clear leaves DONE.
- arm in ARMED, CAPTURE or DONE restarts the machine (to ARMED or CAPTURE as in IDLE). It does not flush the FIFO.
- clear: empties the FIFO (pointers and count to 0), zeroes overflow and drop_cnt, and sets state to IDLE.
  - clear has priority over arm, push and pop in the same cycle.
- Push: writes {pc, addr, wdata} at the write pointer. Pointers wrap modulo DEPTH.
- Pop: rd_valid & rd_ready advances the read pointer. rd_ready while empty has no effect.
- Full with no pop: an eligible event is dropped, overflow is set, and drop_cnt increments (saturating).
- Full with a simultaneous pop: the push is accepted and count is unchanged.
- Empty with a simultaneous push: the pop is ignored (rd_valid was 0) and count becomes 1.
- Read port is first-word-fall-through: rd_pc, rd_addr and rd_wdata show the head entry whenever rd_valid=1. They are don't-care when rd_valid=0.

## Timing
- All outputs reset to 0: rd_valid=0, count=0, overflow=0, drop_cnt=0, state=IDLE.
- Reset asserted mid-capture discards all entries immediately (asynchronous).
- Push latency: a store sampled at edge N gives count+1 and rd_valid=1 after edge N. Head data is valid in the cycle following edge N.
- Pop latency: handshake at edge N means the next entry (or rd_valid=0) is presented after edge N.
- State transitions take effect at the sampling edge. arm at edge N means state is ARMED/CAPTURE from edge N on.
- The trigger compare uses the current-cycle pc with no delay.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Basic capture: trig_en=0, arm, then three stores (pc 0x00400000/addr 0x10/wdata 0x11, then +4/0x14/0x22, then +8/0x18/0x33) → count=3, entries read in order with rd_ready held high, rd_valid drops the cycle after the third pop.
- Trigger: trig_en=1, trig_pc=0x0040001C, arm; stores at pc 0x00400010 and 0x00400014 are ignored. A store at 0x0040001C with addr 0x20/wdata 0xAB → state goes ARMED to CAPTURE, and that store is the first entry.
- Overflow (DEPTH=16, stop_on_full=0): 20 stores with no reads → count=16, overflow=1, drop_cnt=4, and the first 16 stores are read back intact.
- Stop on full (stop_on_full=1): 16 stores → state=DONE. Then pop 2 and issue 3 more stores → count=14, drop_cnt=0, state stays DONE.
- Full plus simultaneous push and pop: count=16, rd_ready=1 and a store in the same cycle → count stays 16, no drop, new entry at the tail.
- clear and reset: clear together with arm while count=5 and drop_cnt=2 → count=0, drop_cnt=0, state=IDLE. Asserting reset low mid-capture → all outputs 0 immediately.
